// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encodings and the width of the state register.
package serial_adder_ctrl_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// 1-bit full adder datapath cell, reused one bit per clock by the
// serial adder controller.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: walks one full_adder across WIDTH operand bits, LSB
// first, one bit per clock. Result/flags are only updated on completion.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int CNT_W = $clog2(WIDTH);
   // cnt values on which the carry into the MSB, and the MSB itself, are produced
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(WIDTH - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state, state_nxt;
   logic             load;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh;
   logic             carry, c_msb_in;
   logic [CNT_W-1:0] cnt;
   logic             fa_sum, fa_cout;

   full_adder u_fa (
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Next-state logic; a new request is accepted in IDLE and in the DONE cycle
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt == CNT_LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Operand/result shifters, carry chain and result capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         res_sh   <= '0;
         carry    <= 1'b0;
         c_msb_in <= 1'b0;
         cnt      <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         a_sh   <= a_sh >> 1;
         b_sh   <= b_sh >> 1;
         res_sh <= {fa_sum, res_sh[WIDTH-1:1]};
         carry  <= fa_cout;
         cnt    <= cnt + 1'b1;
         if (cnt == CNT_PRE) c_msb_in <= fa_cout;
         if (cnt == CNT_LAST) begin
            sum      <= {fa_sum, res_sh[WIDTH-1:1]};
            cout     <= fa_cout;
            overflow <= c_msb_in ^ fa_cout;
         end
      end
   end

   // busy/done are decoded from the registered state, so they change on the edge
   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: table-driven additions checked through a
// scoreboard queue, plus hand sequences for ignored start, back-to-back
// and asynchronous abort.
module tb_serial_adder_ctrl;

   localparam int WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } vec_t;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [WIDTH-1:0] a = '0, b = '0;
   logic             cin = 1'b0;
   logic             busy, done, cout, overflow;
   logic [WIDTH-1:0] sum;

   int               checks = 0;
   int               errors = 0;
   exp_t             sb[$];
   logic [WIDTH-1:0] last_sum = '0;

   serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .cin      (cin),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .cout     (cout),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer add; signed overflow from operand/result signs
   function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                  input logic c);
      exp_t        e;
      logic [WIDTH:0] s;
      s      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      e.sum  = s[WIDTH-1:0];
      e.cout = s[WIDTH];
      e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Scoreboard consumer: every done pulse must match the oldest expectation
   always @(posedge clk) begin
      #1;
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: sum 0x%0h with no request pending", sum);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_sum", 32'(sum), 32'(e.sum));
            chk("sb_cout", 32'(cout), 32'(e.cout));
            chk("sb_ovf", 32'(overflow), 32'(e.ovf));
            last_sum = e.sum;
         end
      end
   end

   // Drive one accepted start, scramble the operands afterwards
   task automatic launch(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic c, input bit expect_result);
      start = 1'b1;
      a     = x;
      b     = y;
      cin   = c;
      if (expect_result) sb.push_back(model(x, y, c));
      tick();
      start = 1'b0;
      a     = WIDTH'($urandom);
      b     = WIDTH'($urandom);
      cin   = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 32'd1);
   endtask

   // Count edges until done, checking the old result is held meanwhile
   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 40) begin
         if (busy) chk("sum_held", 32'(sum), 32'(last_sum));
         tick();
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done after %0d cycles, required within %0d", n, WIDTH);
      end
   endtask

   vec_t vecs[7];
   int   n;

   initial begin
      vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[6] = '{8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1};

      // Reset state
      repeat (2) tick();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sum", 32'(sum), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      rst = 1'b0;
      tick();

      // Table: each entry's expected outputs go to the scoreboard
      for (int i = 0; i < 7; i++) begin
         start = 1'b1;
         a     = vecs[i].a;
         b     = vecs[i].b;
         cin   = vecs[i].cin;
         sb.push_back('{vecs[i].sum, vecs[i].cout, vecs[i].ovf});
         tick();
         start = 1'b0;
         a     = WIDTH'($urandom);
         b     = WIDTH'($urandom);
         chk("busy_after_accept", 32'(busy), 32'd1);
         wait_done(n);
         chk("latency", 32'(n), 32'(WIDTH));
         tick();
         chk("done_one_cycle", 32'(done), 32'd0);
         chk("idle_not_busy", 32'(busy), 32'd0);
      end

      // Start during RUN is ignored
      launch(8'h10, 8'h20, 1'b0, 1'b1);
      repeat (3) tick();
      start = 1'b1;
      a     = 8'hAA;
      b     = 8'h55;
      tick();
      start = 1'b0;
      a     = 8'h0F;
      wait_done(n);
      chk("ignored_start_latency", 32'(n), 32'(WIDTH - 4));
      tick();

      // Back-to-back: new start accepted in the DONE cycle
      launch(8'h03, 8'h04, 1'b0, 1'b1);
      wait_done(n);
      chk("b2b_first_latency", 32'(n), 32'(WIDTH));
      launch(8'h01, 8'h01, 1'b0, 1'b1);
      chk("b2b_done_drop", 32'(done), 32'd0);
      wait_done(n);
      chk("b2b_second_latency", 32'(n), 32'(WIDTH));
      tick();

      // Asynchronous reset in RUN cycle 4: no done for the aborted add
      launch(8'h11, 8'h22, 1'b0, 1'b0);
      repeat (3) tick();
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_sum", 32'(sum), 32'd0);
      chk("abort_cout", 32'(cout), 32'd0);
      chk("abort_ovf", 32'(overflow), 32'd0);
      last_sum = '0;
      tick();
      rst = 1'b0;
      repeat (WIDTH + 2) tick();
      chk("abort_no_done", 32'(done), 32'd0);
      launch(8'h05, 8'h06, 1'b0, 1'b1);
      wait_done(n);
      chk("post_abort_latency", 32'(n), 32'(WIDTH));
      repeat (2) tick();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller: sequences one full_adder instance over WIDTH clock cycles to add two WIDTH-bit operands plus a carry-in.
- Sits between a requester (start/done handshake) and the existing 1-bit full_adder datapath cell.
- Trades latency for area compared with a ripple chain of WIDTH full adders.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; operands are sampled on the edge where start=1 is accepted.
- a  in  WIDTH  operand A, unsigned or two's-complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for bit 0.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held stable from done until the next accepted start.
- cout  out  1  carry out of bit WIDTH-1.
- overflow  out  1  signed overflow, computed as carry into MSB XOR carry out of MSB.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, and internal shift registers, carry and counter all 0.
- States: IDLE, RUN, DONE. Encoding is a 2-bit localparam set.
- IDLE:
  - On start=1, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0. Go to RUN; busy<=1.
- RUN, one bit per edge:
  - Drive full_adder with (a_sh[0], b_sh[0], carry).
  - Shift a_sh and b_sh right by 1.
  - Shift the full_adder sum bit into res_sh at the MSB, shifting res_sh right.
  - carry<=full_adder cout; cnt<=cnt+1.
  - When cnt==WIDTH-2, capture carry into c_msb_in (carry into the MSB).
  - When cnt==WIDTH-1:
    - sum<=final res_sh with the new bit; cout<=full_adder cout; overflow<=c_msb_in ^ full_adder cout.
    - done<=1, busy<=0, go to DONE.
- DONE, lasts exactly one cycle:
  - done<=0 on the next edge.
  - If start=1 on that edge, load new operands and go to RUN, with busy<=1. Otherwise go to IDLE.
- Latency: with start sampled on edge E0, bit k is computed on edge E(k+1) and done rises on edge E(WIDTH). Throughput is one addition per WIDTH cycles (back-to-back via DONE).
- start while busy=1 (RUN) is ignored. Operands are not re-sampled and no error is flagged.
- Changes on a, b, cin after the accepting edge have no effect on the result in progress.
- sum, cout and overflow are not modified during RUN. They keep the previous result until done.
- Counter width is $clog2(WIDTH). There is no wrap past WIDTH-1, because the state leaves RUN.
- rst asserted mid-RUN aborts immediately to reset values. No done pulse is produced for the aborted operation.
- Arithmetic: the result equals (a + b + cin) mod 2^WIDTH, and cout equals bit WIDTH of the full sum.

Decomposition:
- Shared package/header holds the state encodings (ST_IDLE=0, ST_RUN=1, ST_DONE=2) and the STATE_W=2 constant.
- One sub-module: the existing full_adder (a, b, cin -> sum, cout), instantiated once as the datapath.
- Controller FSM, shift registers and counter live in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, cin=0, start pulse -> busy high for 8 cycles; done on the 8th edge after acceptance; sum=0x08, cout=0, overflow=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, overflow=1. a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
- Start 0x10+0x20. Pulse start with a=0xAA, b=0x55 at cycle 3 of RUN and change the operands -> ignored; sum=0x30. Previous sum stays held during RUN.
- Assert start in the DONE cycle with 0x01+0x01 -> done drops, busy rises the same edge; second done 8 edges later with sum=0x02.
- Assert rst asynchronously mid-RUN (cycle 4) -> all outputs 0 immediately, state IDLE, no done. The next start completes normally.
